scan_sel_gen: RTL
=================

# scan_sel_gen

Channel-select sequencer that drives the 4-bit select input of the 4-to-16 one-hot decoder. It scans a masked set of the 16 channels in ascending or descending order and holds each channel for a programmable dwell time. It runs either continuously or as a single pass, and gives downstream logic valid, step and done strobes.

## Interface
- `DWELL_W`, default 8: width of the dwell count; each channel is held for `dwell`+1 cycles.
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a scan; level-sampled and acted on only in IDLE.
- `stop` in 1: abort the scan; sampled every cycle.
- `dir` in 1: 0 = ascending (0→15), 1 = descending (15→0). Latched at start.
- `single` in 1: 1 = one pass then stop, 0 = wrap forever. Latched at start.
- `dwell` in DWELL_W: hold count minus one. Latched at start.
- `mask` in 16: bit n=1 enables channel n. Latched at start.
- `sel` out 4: current channel code; feeds the decoder's 4-bit select input.
- `sel_valid` out 1: `sel` is an active scan channel.
- `step` out 1: one-cycle pulse on the first cycle of each channel dwell.
- `busy` out 1: FSM is in RUN.
- `done` out 1: one-cycle pulse when a single pass completes.

## Operation
- FSM states: IDLE and RUN. All outputs are registered.
- **Reset:**
  - FSM goes to IDLE.
  - `sel`=0, `sel_valid`=0, `step`=0, `busy`=0, `done`=0.
  - The dwell counter and all latched config registers clear to 0.
- **IDLE, start=1, stop=0, mask≠0:**
  - Latch `dir`, `single`, `dwell` and `mask`.
  - Load `sel` with the first enabled channel: the lowest set mask bit when ascending, the highest when descending.
  - Set `sel_valid`=1, `step`=1, `busy`=1.
  - Load the dwell counter with `dwell`.
  - Go to RUN.
- **IDLE, start=1, mask=0:** ignored; stay in IDLE and no output changes.
- **RUN, counter≠0:** decrement the counter; `sel` is held and `step`=0.
- **RUN, counter=0, next channel is the next enabled channel in scan direction from `sel`:**
  - If no wrap would occur, or `single`=0: `sel` takes the next channel, `step`=1, and the counter reloads with the latched dwell.
  - The wrap cases are ascending past 15 and descending past 0.
- **Wrap case with `single`=1:**
  - Go to IDLE with `done`=1, `sel_valid`=0, `busy`=0.
  - `sel` keeps the last channel.
- **Only one enabled channel and `single`=0:** `sel` is unchanged but `step` re-pulses every `dwell`+1 cycles.
- **stop=1 in RUN:**
  - Go to IDLE next cycle with `sel_valid`=0, `busy`=0, `done`=0.
  - `sel` is held and no step pulse is issued.
  - stop has priority over counter expiry in the same cycle.
- **Same-cycle and RUN-time input rules:**
  - `start` and `stop` asserted together in IDLE: stop wins and the start is ignored.
  - `start` in RUN is ignored.
  - Changes to `mask`, `dir`, `dwell` or `single` in RUN have no effect until the next start.
- **Next-channel search:** combinational circular priority search over the latched mask, starting at `sel`±1 (mod 16). It resolves in the same cycle with no extra latency.
- **Reset mid-scan:** `rst` in RUN returns every output and register to its reset value on the next edge, overriding all other inputs.

## Timing
- Start latency: `start` sampled at edge t gives the first `sel`, `sel_valid`=1 and `step`=1 after edge t, i.e. visible in cycle t+1.
- Each channel is presented for exactly `dwell`+1 cycles.
  - `dwell`=0 advances every cycle.
  - Maximum hold is 2^DWELL_W cycles.
- A full ascending pass with k enabled channels lasts k·(`dwell`+1) cycles. `done` is asserted in the cycle immediately after the last channel's final dwell cycle.
- Stop latency: one cycle; `busy` falls on the edge that samples `stop`.
- A new `start` is accepted in the cycle after `done` or after a stop, because that cycle is already IDLE.
- The decoder output is valid whenever `sel_valid`=1; `sel` never glitches because it is a register output.

## Test plan
- **Reset state:** assert `rst` for 2 cycles → `sel`=0, `sel_valid`=0, `step`=0, `busy`=0, `done`=0.
- **Ascending single pass:** mask=16'h0091, dir=0, single=1, dwell=2, pulse start → `sel` runs 0,4,7, each held 3 cycles, with `step` pulses 3 cycles apart; then `done`=1 for 1 cycle and `busy`=0 after 9 RUN cycles.
- **Descending continuous wrap:** mask=16'h8001, dir=1, single=0, dwell=0 → `sel` runs 15,0,15,0,… with `step`=1 every cycle and `done` never asserted.
- **Stop mid-dwell:** dwell=5, stop asserted in the 3rd cycle of channel 4 → next cycle `busy`=0, `sel_valid`=0, `sel`=4; a `start` the following cycle restarts from the first enabled channel.
- **Ignored starts:**
  - start with mask=0 → no state change.
  - start and stop in the same cycle → stays in IDLE.
  - start in RUN while changing mask → scan order is unaffected.
- **Reset mid-scan and single channel:**
  - `rst` in RUN at `sel`=9 → all outputs return to their reset values next cycle.
  - Single-channel mask 16'h0020 with single=0, dwell=3 → `sel`=5 constant and `step` every 4 cycles.

Source files
------------

// File: rtl/scan_sel_gen.sv
// Channel-select sequencer for a 4-to-16 one-hot decoder: scans a masked channel
// set up or down, holding each channel for dwell+1 cycles, continuously or once.
module scan_sel_gen #(
    parameter int unsigned DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               dir,
    input  logic               single,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [15:0]        mask,
    output logic [3:0]         sel,
    output logic               sel_valid,
    output logic               step,
    output logic               busy,
    output logic               done
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         sel_q, sel_d;
    logic               sel_valid_q, sel_valid_d;
    logic               step_q, step_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               dir_q, dir_d;
    logic               single_q, single_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [15:0]        mask_q, mask_d;

    logic [3:0]         lo_ch, hi_ch, first_ch;
    logic [3:0]         nxt_ch, cand;
    logic               nxt_found;
    logic               wrap;

    // First enabled channel of the incoming mask: later hits overwrite earlier ones.
    always_comb begin
        lo_ch = '0;
        hi_ch = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (mask[15 - i]) lo_ch = 4'(15 - i);
            if (mask[i])      hi_ch = 4'(i);
        end
        first_ch = dir ? hi_ch : lo_ch;
    end

    // Circular search over the latched mask from sel+/-1; a lone channel finds itself.
    always_comb begin
        nxt_ch    = sel_q;
        nxt_found = 1'b0;
        cand      = sel_q;
        for (int unsigned i = 1; i <= 16; i++) begin
            cand = dir_q ? (sel_q - 4'(i)) : (sel_q + 4'(i));
            if (!nxt_found && mask_q[cand]) begin
                nxt_ch    = cand;
                nxt_found = 1'b1;
            end
        end
        wrap = dir_q ? (nxt_ch >= sel_q) : (nxt_ch <= sel_q);
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        sel_valid_d = sel_valid_q;
        step_d      = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        cnt_d       = cnt_q;
        dir_d       = dir_q;
        single_d    = single_q;
        dwell_d     = dwell_q;
        mask_d      = mask_q;

        unique case (state_q)
            IDLE: begin
                if (start && !stop && (mask != '0)) begin
                    dir_d       = dir;
                    single_d    = single;
                    dwell_d     = dwell;
                    mask_d      = mask;
                    sel_d       = first_ch;
                    sel_valid_d = 1'b1;
                    step_d      = 1'b1;
                    busy_d      = 1'b1;
                    cnt_d       = dwell;
                    state_d     = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    sel_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (wrap && single_q) begin
                    sel_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    state_d     = IDLE;
                end else begin
                    sel_d  = nxt_ch;
                    step_d = 1'b1;
                    cnt_d  = dwell_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            sel_valid_q <= 1'b0;
            step_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cnt_q       <= '0;
            dir_q       <= 1'b0;
            single_q    <= 1'b0;
            dwell_q     <= '0;
            mask_q      <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            sel_valid_q <= sel_valid_d;
            step_q      <= step_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cnt_q       <= cnt_d;
            dir_q       <= dir_d;
            single_q    <= single_d;
            dwell_q     <= dwell_d;
            mask_q      <= mask_d;
        end
    end

    assign sel       = sel_q;
    assign sel_valid = sel_valid_q;
    assign step      = step_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
